// File: rtl/xyolo_write_sched_if.sv
// Bus bundle for the YOLO write-stage sequencer: run/done handshake, pass
// configuration, and the B-side vread/vwrite ports plus xyolo load strobes.
interface xyolo_write_sched_if #(
  parameter int MEM_ADDR_W    = 10,
  parameter int VWRITE_ADDR_W = 10,
  parameter int CNT_W         = 10
);
  logic                     run;
  logic                     done;
  logic [MEM_ADDR_W-1:0]    start_addr;
  logic [MEM_ADDR_W-1:0]    tap_incr;
  logic [MEM_ADDR_W-1:0]    pix_shift;
  logic [CNT_W-1:0]         n_taps;
  logic [CNT_W-1:0]         n_out;
  logic [VWRITE_ADDR_W-1:0] out_base;
  logic                     maxpool;
  logic                     vread_enB;
  logic [MEM_ADDR_W-1:0]    vread_addrB;
  logic                     ld_acc;
  logic                     ld_mp;
  logic                     ld_res;
  logic                     vwrite_enB;
  logic [VWRITE_ADDR_W-1:0] vwrite_addrB;

  // Configuration source side (Versat config registers / controller)
  modport master (
    output run, start_addr, tap_incr, pix_shift, n_taps, n_out, out_base, maxpool,
    input  done, vread_enB, vread_addrB, ld_acc, ld_mp, ld_res, vwrite_enB, vwrite_addrB
  );

  // Sequencer side
  modport slave (
    input  run, start_addr, tap_incr, pix_shift, n_taps, n_out, out_base, maxpool,
    output done, vread_enB, vread_addrB, ld_acc, ld_mp, ld_res, vwrite_enB, vwrite_addrB
  );
endinterface

// File: rtl/xyolo_write_sched.sv
// YOLO write-stage sequencer: issues one vread tap per cycle for a configured
// convolution pass and derives ld_acc/ld_res/ld_mp and vwrite strobes from
// issue-time tags carried through fixed-latency shift registers.
module xyolo_write_sched #(
  parameter int MEM_ADDR_W    = 10,
  parameter int VWRITE_ADDR_W = 10,
  parameter int CNT_W         = 10,
  parameter int RD_LAT        = 2,
  parameter int WR_LAT        = 3
) (
  input logic                clk,
  input logic                rst,
  xyolo_write_sched_if.slave bus
);
  localparam int RES_LAT = RD_LAT + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic                     done_q, done_d;
  logic                     readEn_q, readEn_d;
  logic [MEM_ADDR_W-1:0]    rdAddr_q, rdAddr_d;
  logic [MEM_ADDR_W-1:0]    base_q, base_d;
  logic [MEM_ADDR_W-1:0]    tapIncr_q, tapIncr_d;
  logic [MEM_ADDR_W-1:0]    pixShift_q, pixShift_d;
  logic [CNT_W-1:0]         nTaps_q, nTaps_d;
  logic [CNT_W-1:0]         nOut_q, nOut_d;
  logic [CNT_W-1:0]         tapCnt_q, tapCnt_d;
  logic [CNT_W-1:0]         outCnt_q, outCnt_d;
  logic                     maxpool_q, maxpool_d;
  logic [VWRITE_ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [RD_LAT-1:0]        accPipe_q, accPipe_d;
  logic [RES_LAT-1:0]       resPipe_q, resPipe_d;
  logic [RES_LAT-1:0]       mpPipe_q, mpPipe_d;
  logic [RES_LAT-1:0]       wrTagPipe_q, wrTagPipe_d;
  logic [WR_LAT-1:0]        wrPipe_q, wrPipe_d;

  logic lastTap, lastOut, firstTag, lastTag, mpTag, wrTag;

  // Next-state logic: FSM, tap/output counters, address generation and strobe tags
  always_comb begin
    state_d     = state_q;
    tapIncr_d   = tapIncr_q;
    pixShift_d  = pixShift_q;
    nTaps_d     = nTaps_q;
    nOut_d      = nOut_q;
    maxpool_d   = maxpool_q;
    tapCnt_d    = tapCnt_q;
    outCnt_d    = outCnt_q;
    base_d      = base_q;
    rdAddr_d    = rdAddr_q;
    wrAddr_d    = wrAddr_q;

    lastTap  = (tapCnt_q == nTaps_q - CNT_W'(1));
    lastOut  = (outCnt_q == nOut_q - CNT_W'(1));
    firstTag = readEn_q && (tapCnt_q == '0);
    lastTag  = readEn_q && lastTap;
    mpTag    = maxpool_q && (outCnt_q[1:0] != 2'd0);
    wrTag    = !maxpool_q || (outCnt_q[1:0] == 2'd3) || lastOut;

    accPipe_d      = '0;
    resPipe_d      = '0;
    mpPipe_d       = '0;
    wrTagPipe_d    = '0;
    wrPipe_d       = '0;
    accPipe_d[0]   = firstTag;
    resPipe_d[0]   = lastTag;
    mpPipe_d[0]    = lastTag && mpTag;
    wrTagPipe_d[0] = lastTag && wrTag;
    wrPipe_d[0]    = wrTagPipe_q[RES_LAT-1];
    for (int k = 1; k < RD_LAT; k++) accPipe_d[k] = accPipe_q[k-1];
    for (int k = 1; k < RES_LAT; k++) begin
      resPipe_d[k]   = resPipe_q[k-1];
      mpPipe_d[k]    = mpPipe_q[k-1];
      wrTagPipe_d[k] = wrTagPipe_q[k-1];
    end
    for (int k = 1; k < WR_LAT; k++) wrPipe_d[k] = wrPipe_q[k-1];

    if (wrPipe_q[WR_LAT-1]) wrAddr_d = wrAddr_q + VWRITE_ADDR_W'(1);

    case (state_q)
      IDLE: begin
        if (bus.run && (bus.n_taps != '0) && (bus.n_out != '0)) begin
          state_d    = ISSUE;
          tapIncr_d  = bus.tap_incr;
          pixShift_d = bus.pix_shift;
          nTaps_d    = bus.n_taps;
          nOut_d     = bus.n_out;
          maxpool_d  = bus.maxpool;
          tapCnt_d   = '0;
          outCnt_d   = '0;
          base_d     = bus.start_addr;
          rdAddr_d   = bus.start_addr;
          wrAddr_d   = bus.out_base;
        end
      end
      ISSUE: begin
        if (lastTap) begin
          if (lastOut) begin
            state_d = DRAIN;
          end else begin
            tapCnt_d = '0;
            outCnt_d = outCnt_q + CNT_W'(1);
            base_d   = base_q + pixShift_q;
            rdAddr_d = base_q + pixShift_q;
          end
        end else begin
          tapCnt_d = tapCnt_q + CNT_W'(1);
          rdAddr_d = rdAddr_q + tapIncr_q;
        end
      end
      DRAIN: begin
        if ((accPipe_d == '0) && (resPipe_d == '0) && (wrPipe_d == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    readEn_d = (state_d == ISSUE);
    done_d   = (state_d == IDLE);
  end

  // State and output registers, cleared asynchronously so a mid-pass reset kills all strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      done_q      <= 1'b1;
      readEn_q    <= 1'b0;
      rdAddr_q    <= '0;
      base_q      <= '0;
      tapIncr_q   <= '0;
      pixShift_q  <= '0;
      nTaps_q     <= '0;
      nOut_q      <= '0;
      tapCnt_q    <= '0;
      outCnt_q    <= '0;
      maxpool_q   <= 1'b0;
      wrAddr_q    <= '0;
      accPipe_q   <= '0;
      resPipe_q   <= '0;
      mpPipe_q    <= '0;
      wrTagPipe_q <= '0;
      wrPipe_q    <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      readEn_q    <= readEn_d;
      rdAddr_q    <= rdAddr_d;
      base_q      <= base_d;
      tapIncr_q   <= tapIncr_d;
      pixShift_q  <= pixShift_d;
      nTaps_q     <= nTaps_d;
      nOut_q      <= nOut_d;
      tapCnt_q    <= tapCnt_d;
      outCnt_q    <= outCnt_d;
      maxpool_q   <= maxpool_d;
      wrAddr_q    <= wrAddr_d;
      accPipe_q   <= accPipe_d;
      resPipe_q   <= resPipe_d;
      mpPipe_q    <= mpPipe_d;
      wrTagPipe_q <= wrTagPipe_d;
      wrPipe_q    <= wrPipe_d;
    end
  end

  assign bus.done         = done_q;
  assign bus.vread_enB    = readEn_q;
  assign bus.vread_addrB  = rdAddr_q;
  assign bus.ld_acc       = accPipe_q[RD_LAT-1];
  assign bus.ld_res       = resPipe_q[RES_LAT-1];
  assign bus.ld_mp        = mpPipe_q[RES_LAT-1];
  assign bus.vwrite_enB   = wrPipe_q[WR_LAT-1];
  assign bus.vwrite_addrB = wrAddr_q;
endmodule

// File: tb/tb_xyolo_write_sched.sv
// Self-checking bench for xyolo_write_sched: a cycle-stamped scoreboard of
// expected reads, strobes and writes is filled when each pass is started and
// drained by a negedge monitor as the DUT produces them.
module tb_xyolo_write_sched;
  localparam int MEM_ADDR_W    = 10;
  localparam int VWRITE_ADDR_W = 10;
  localparam int CNT_W         = 10;
  localparam int RD_LAT        = 2;
  localparam int WR_LAT        = 3;
  localparam int MEM_SPAN      = 1 << MEM_ADDR_W;
  localparam int WR_SPAN       = 1 << VWRITE_ADDR_W;

  typedef struct {
    int cyc;
    int addr;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;
  bit   monOn;
  int   busyStart;
  int   busyEnd;
  int   mpSeen;
  int   wrSeen;
  int   resSeen;
  ev_t  rdQ[$];
  ev_t  wrQ[$];
  int   accQ[$];
  int   resQ[$];
  int   mpQ[$];
  ev_t  mEv;
  int   mCyc;
  bit   mExpDone;

  xyolo_write_sched_if #(
    .MEM_ADDR_W(MEM_ADDR_W), .VWRITE_ADDR_W(VWRITE_ADDR_W), .CNT_W(CNT_W)
  ) bus ();

  xyolo_write_sched #(
    .MEM_ADDR_W(MEM_ADDR_W), .VWRITE_ADDR_W(VWRITE_ADDR_W), .CNT_W(CNT_W),
    .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle index; cycle N is the interval after the N-th rising edge
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pending();
    return rdQ.size() + wrQ.size() + accQ.size() + resQ.size() + mpQ.size();
  endfunction

  // Drive a pass configuration, push its expected events, then pulse run for one cycle
  task automatic applyStimulus(input int nTaps, input int nOut, input int sa, input int ti,
                               input int ps, input int ob, input bit mp);
    int base;
    int c;
    int wcnt;
    bus.start_addr = MEM_ADDR_W'(sa);
    bus.tap_incr   = MEM_ADDR_W'(ti);
    bus.pix_shift  = MEM_ADDR_W'(ps);
    bus.n_taps     = CNT_W'(nTaps);
    bus.n_out      = CNT_W'(nOut);
    bus.out_base   = VWRITE_ADDR_W'(ob);
    bus.maxpool    = mp;
    base = cyc;
    wcnt = 0;
    for (int o = 0; o < nOut; o++) begin
      for (int t = 0; t < nTaps; t++) begin
        c = base + 1 + o * nTaps + t;
        rdQ.push_back('{c, (sa + o * ps + t * ti) % MEM_SPAN});
        if (t == 0) accQ.push_back(c + RD_LAT);
        if (t == nTaps - 1) begin
          resQ.push_back(c + RD_LAT + 1);
          if (mp && (o % 4 != 0)) mpQ.push_back(c + RD_LAT + 1);
          if (!mp || (o % 4 == 3) || (o == nOut - 1)) begin
            wrQ.push_back('{c + RD_LAT + 1 + WR_LAT, (ob + wcnt) % WR_SPAN});
            wcnt++;
          end
        end
      end
    end
    busyStart = base + 1;
    busyEnd   = base + 1 + nTaps * nOut + RD_LAT + 1 + WR_LAT;
    bus.run = 1'b1;
    @(posedge clk);
    #1;
    bus.run = 1'b0;
  endtask

  // Scoreboard monitor: done level every cycle, and each asserted enable/strobe against its queue
  always @(negedge clk) begin
    if (monOn) begin
      mExpDone = (cyc < busyStart) || (cyc >= busyEnd);
      tests++;
      if (bus.done !== mExpDone) begin
        fails++;
        $display("[TB] FAIL done cycle %0d got %b expected %b", cyc, bus.done, mExpDone);
      end
      if (bus.vread_enB === 1'b1) begin
        tests++;
        if (rdQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL vread unexpected at cycle %0d addr %0d", cyc, bus.vread_addrB);
        end else begin
          mEv = rdQ.pop_front();
          if (mEv.cyc != cyc || mEv.addr != int'(bus.vread_addrB)) begin
            fails++;
            $display("[TB] FAIL vread got cycle %0d addr %0d expected cycle %0d addr %0d",
                     cyc, bus.vread_addrB, mEv.cyc, mEv.addr);
          end
        end
      end
      if (bus.ld_acc === 1'b1) begin
        tests++;
        if (accQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL ld_acc unexpected at cycle %0d", cyc);
        end else begin
          mCyc = accQ.pop_front();
          if (mCyc != cyc) begin
            fails++;
            $display("[TB] FAIL ld_acc got cycle %0d expected cycle %0d", cyc, mCyc);
          end
        end
      end
      if (bus.ld_res === 1'b1) begin
        tests++;
        resSeen++;
        if (resQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL ld_res unexpected at cycle %0d", cyc);
        end else begin
          mCyc = resQ.pop_front();
          if (mCyc != cyc) begin
            fails++;
            $display("[TB] FAIL ld_res got cycle %0d expected cycle %0d", cyc, mCyc);
          end
        end
      end
      if (bus.ld_mp === 1'b1) begin
        tests++;
        mpSeen++;
        if (mpQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL ld_mp unexpected at cycle %0d", cyc);
        end else begin
          mCyc = mpQ.pop_front();
          if (mCyc != cyc) begin
            fails++;
            $display("[TB] FAIL ld_mp got cycle %0d expected cycle %0d", cyc, mCyc);
          end
        end
      end
      if (bus.vwrite_enB === 1'b1) begin
        tests++;
        wrSeen++;
        if (wrQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL vwrite unexpected at cycle %0d addr %0d", cyc, bus.vwrite_addrB);
        end else begin
          mEv = wrQ.pop_front();
          if (mEv.cyc != cyc || mEv.addr != int'(bus.vwrite_addrB)) begin
            fails++;
            $display("[TB] FAIL vwrite got cycle %0d addr %0d expected cycle %0d addr %0d",
                     cyc, bus.vwrite_addrB, mEv.cyc, mEv.addr);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    #2;
    tests++;
    if (bus.done !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_done got %b expected 1", bus.done);
    end
    tests++;
    if ({bus.vread_enB, bus.ld_acc, bus.ld_mp, bus.ld_res, bus.vwrite_enB} !== 5'b0) begin
      fails++;
      $display("[TB] FAIL reset_strobes got %b expected 00000",
               {bus.vread_enB, bus.ld_acc, bus.ld_mp, bus.ld_res, bus.vwrite_enB});
    end
    tests++;
    if (bus.vread_addrB !== '0 || bus.vwrite_addrB !== '0) begin
      fails++;
      $display("[TB] FAIL reset_addr got rd %0d wr %0d expected 0 0", bus.vread_addrB, bus.vwrite_addrB);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    monOn = 1'b1;
  endtask

  task automatic test_basic();
    applyStimulus(3, 2, 0, 1, 3, 8, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (bus.ld_acc !== 1'b1 || bus.ld_res !== 1'b1) begin
      fails++;
      $display("[TB] FAIL basic_acc_res_overlap got acc %b res %b expected 1 1", bus.ld_acc, bus.ld_res);
    end
    repeat (busyEnd - cyc + 2) @(negedge clk);
    tests++;
    if (pending() != 0) begin
      fails++;
      $display("[TB] FAIL basic_pending got %0d events outstanding expected 0", pending());
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(3, 2, 0, 1, 3, 8, 1'b0);
    repeat (busyEnd - cyc + 1) @(negedge clk);
    applyStimulus(2, 3, 40, 5, 2, 100, 1'b0);
    repeat (busyEnd - cyc + 2) @(negedge clk);
    tests++;
    if (pending() != 0) begin
      fails++;
      $display("[TB] FAIL rearm_pending got %0d events outstanding expected 0", pending());
    end
  endtask

  task automatic test_maxpool();
    mpSeen = 0;
    wrSeen = 0;
    resSeen = 0;
    applyStimulus(1, 8, 16, 1, 1, 20, 1'b1);
    repeat (busyEnd - cyc + 2) @(negedge clk);
    tests++;
    if (mpSeen != 6 || wrSeen != 2 || resSeen != 8) begin
      fails++;
      $display("[TB] FAIL maxpool_counts got mp %0d wr %0d res %0d expected 6 2 8", mpSeen, wrSeen, resSeen);
    end
    mpSeen = 0;
    wrSeen = 0;
    applyStimulus(2, 5, 200, 3, 7, 60, 1'b1);
    repeat (busyEnd - cyc + 2) @(negedge clk);
    tests++;
    if (mpSeen != 3 || wrSeen != 2) begin
      fails++;
      $display("[TB] FAIL maxpool_partial got mp %0d wr %0d expected 3 2", mpSeen, wrSeen);
    end
    tests++;
    if (pending() != 0) begin
      fails++;
      $display("[TB] FAIL maxpool_pending got %0d events outstanding expected 0", pending());
    end
  endtask

  task automatic test_zero_count();
    wrSeen = 0;
    bus.n_taps = CNT_W'(3);
    bus.n_out  = '0;
    bus.run = 1'b1;
    @(posedge clk);
    #1;
    bus.run = 1'b0;
    repeat (12) @(negedge clk);
    bus.n_taps = '0;
    bus.n_out  = CNT_W'(2);
    bus.run = 1'b1;
    @(posedge clk);
    #1;
    bus.run = 1'b0;
    repeat (12) @(negedge clk);
    tests++;
    if (bus.done !== 1'b1 || wrSeen != 0) begin
      fails++;
      $display("[TB] FAIL zero_count got done %b writes %0d expected 1 0", bus.done, wrSeen);
    end
  endtask

  task automatic test_wrap();
    applyStimulus(4, 1, 1022, 1, 0, 5, 1'b0);
    repeat (busyEnd - cyc + 2) @(negedge clk);
    applyStimulus(1, 3, 1020, 0, 2, 1023, 1'b0);
    repeat (busyEnd - cyc + 2) @(negedge clk);
    tests++;
    if (pending() != 0) begin
      fails++;
      $display("[TB] FAIL wrap_pending got %0d events outstanding expected 0", pending());
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(3, 2, 0, 1, 3, 8, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    busyEnd = cyc;
    rdQ.delete();
    wrQ.delete();
    accQ.delete();
    resQ.delete();
    mpQ.delete();
    #1;
    tests++;
    if (bus.done !== 1'b1) begin
      fails++;
      $display("[TB] FAIL midreset_done got %b expected 1", bus.done);
    end
    tests++;
    if ({bus.vread_enB, bus.ld_acc, bus.ld_mp, bus.ld_res, bus.vwrite_enB} !== 5'b0) begin
      fails++;
      $display("[TB] FAIL midreset_strobes got %b expected 00000",
               {bus.vread_enB, bus.ld_acc, bus.ld_mp, bus.ld_res, bus.vwrite_enB});
    end
    tests++;
    if (bus.vread_addrB !== '0 || bus.vwrite_addrB !== '0) begin
      fails++;
      $display("[TB] FAIL midreset_addr got rd %0d wr %0d expected 0 0", bus.vread_addrB, bus.vwrite_addrB);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_ignored_run();
    applyStimulus(3, 2, 0, 1, 3, 8, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    bus.start_addr = MEM_ADDR_W'(100);
    bus.n_taps     = CNT_W'(1);
    bus.n_out      = CNT_W'(7);
    bus.out_base   = VWRITE_ADDR_W'(50);
    bus.maxpool    = 1'b1;
    bus.run = 1'b1;
    @(posedge clk);
    #1;
    bus.run = 1'b0;
    repeat (busyEnd - cyc + 2) @(negedge clk);
    tests++;
    if (pending() != 0) begin
      fails++;
      $display("[TB] FAIL ignored_run_pending got %0d events outstanding expected 0", pending());
    end
  endtask

  // Hard time limit so the bench always ends even if something stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Test sequence
  initial begin
    cyc = 0;
    tests = 0;
    fails = 0;
    monOn = 1'b0;
    busyStart = 0;
    busyEnd = 0;
    mpSeen = 0;
    wrSeen = 0;
    resSeen = 0;
    rst = 1'b0;
    bus.run = 1'b0;
    bus.start_addr = '0;
    bus.tap_incr = '0;
    bus.pix_shift = '0;
    bus.n_taps = '0;
    bus.n_out = '0;
    bus.out_base = '0;
    bus.maxpool = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_maxpool();
    test_zero_count();
    test_wrap();
    test_reset_mid();
    test_ignored_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/xyolo_write_sched.md
# xyolo_write_sched

Control sequencer for the YOLO write stage. It generates the internal-port ("B" side) addresses and enables for the stage's vread pixel memory and vwrite result memories, plus the `ld_acc`/`ld_mp`/`ld_res` strobes for the xyolo units. The stage runs one configured convolution pass per `run` pulse: `n_out` output pixels, each accumulated over `n_taps` input taps. Optional 4:1 maxpool grouping is supported. The block sits beside the write stage and is configured from the same Versat config registers as the external address generators.

## Interface
Parameters:
- `MEM_ADDR_W`, 10, vread internal read address width
- `VWRITE_ADDR_W`, 10, vwrite internal write address width
- `CNT_W`, 10, width of tap and output counters
- `RD_LAT`, 2, cycles from `vread_enB` to pixel valid at the xyolo input (memory read plus output register)
- `WR_LAT`, 3, cycles from `ld_res` to `flow_out` valid

Ports (reset is asynchronous and active-high; one clock):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `run`  in  1  single-cycle start pulse; ignored while busy
- `done`  out  1  high while idle; low from the cycle after an accepted `run` until the pass completes
- `start_addr`  in  `MEM_ADDR_W`  read address of tap 0 of output 0
- `tap_incr`  in  `MEM_ADDR_W`  read address step between taps
- `pix_shift`  in  `MEM_ADDR_W`  step of the per-output base address
- `n_taps`  in  `CNT_W`  taps per output
- `n_out`  in  `CNT_W`  outputs per pass
- `out_base`  in  `VWRITE_ADDR_W`  first vwrite address
- `maxpool`  in  1  enable 4:1 output grouping
- `vread_enB`  out  1  vread read enable
- `vread_addrB`  out  `MEM_ADDR_W`  vread read address
- `ld_acc`  out  1  restart accumulation with the current pixel
- `ld_mp`  out  1  merge the result into the maxpool register
- `ld_res`  out  1  latch the accumulator into the result
- `vwrite_enB`  out  1  vwrite write enable
- `vwrite_addrB`  out  `VWRITE_ADDR_W`  vwrite write address

## Operation
- The FSM has three states: IDLE, ISSUE, DRAIN.
- **IDLE → ISSUE:** taken on `run` when `n_taps != 0` and `n_out != 0`.
  - All config inputs are captured into shadow registers on the accepted `run`.
  - A `run` with either count equal to 0 stays in IDLE. `done` stays high and no strobes are produced.
- **ISSUE:** exactly one tap is issued per cycle, with no bubbles between outputs.
  - `vread_enB` = 1.
  - `vread_addrB` = base + tap·`tap_incr`.
  - base starts at `start_addr` and advances by `pix_shift` after each output's last tap.
  - All address arithmetic wraps modulo 2^`MEM_ADDR_W`.
- **ISSUE → DRAIN:** after the last tap of the last output.
- **DRAIN → IDLE:** when the strobe delay lines are empty, i.e. the cycle after the final `vwrite_enB`.
- **Strobes:** each is a delayed copy of an issue-time tag, carried in shift registers.
  - `ld_acc` = tap 0 issue delayed by `RD_LAT`.
  - `ld_res` = last-tap issue delayed by `RD_LAT`+1.
  - `ld_acc` and `ld_res` may be high in the same cycle (back-to-back outputs); this is legal and required.
- **Maxpool = 0:** every `ld_res` produces `vwrite_enB` `WR_LAT` cycles later. `ld_mp` is never asserted.
- **Maxpool = 1:** outputs are grouped in fours by output index mod 4 (group position 0–3).
  - `ld_mp` is asserted together with `ld_res` for positions 1, 2 and 3.
  - `vwrite_enB` fires only for position 3.
  - If `n_out` is not a multiple of 4, the trailing partial group also writes on its last output.
- **Write address:** `vwrite_addrB` starts at `out_base` and increments after each write, wrapping modulo 2^`VWRITE_ADDR_W`.
- **`run` while not IDLE:** ignored; the configuration is not re-captured.
- **`rst` mid-pass:** returns to IDLE immediately and clears all counters and delay lines. No further strobes are emitted.

## Timing
- **Reset values:** `done`=1. All enables and strobes = 0. `vread_addrB`=0, `vwrite_addrB`=0.
- All outputs are registered.
- **Issue timing:** with `run` sampled at cycle 0, the first `vread_enB` is at cycle 1 and `done` falls at cycle 1.
- **Issue-phase length:** `n_taps`·`n_out` cycles.
- **Final write:** the last `vwrite_enB` is at cycle `n_taps`·`n_out` + `RD_LAT` + 1 + `WR_LAT`.
- **Completion:** `done` rises the following cycle.
- **Re-arm:** a `run` is accepted in the same cycle `done` is first high.

## Test plan
- **Basic pass:** `n_taps`=3, `n_out`=2, `start_addr`=0, `tap_incr`=1, `pix_shift`=3, `out_base`=8, `run` at cycle 0.
  - `vread_addrB` = 0..5 on cycles 1–6.
  - `ld_acc` on cycles 3 and 6; `ld_res` on cycles 6 and 9.
  - `vwrite_enB` at cycle 9 (addr 8) and cycle 12 (addr 9).
  - `done` low on cycles 1–12, high again at cycle 13.
- **Maxpool:** `maxpool`=1, `n_taps`=1, `n_out`=8 → `ld_mp` on 6 of the 8 `ld_res` pulses; exactly 2 writes, at addresses `out_base` and `out_base`+1.
- **Zero count:** `n_out`=0 with a `run` pulse → `done` stays 1 and no enable is ever asserted.
- **Wrap-around:** `start_addr`=1022, `tap_incr`=1, `n_taps`=4, `n_out`=1 → read addresses 1022, 1023, 0, 1.
- **Reset mid-pass and ignored `run`:**
  - Assert `rst` at cycle 4 of the basic pass → all outputs return to reset values in that same cycle, and no strobe appears afterwards.
  - A `run` pulse during ISSUE is ignored, and the pass completes unchanged.
